// File: rtl/rr_quota_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//   Shared types and default sizing for the round-robin quota arbiter.
//   Contents:
//      arb_state_e       arbiter FSM states (idle, owner holding, dead gap)
//      ARB_N_REQ_DEF     default number of requesters
//      ARB_QUOTA_DEF     default hold quota while others are waiting
// ----------------------------------------------------------------------------
package arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_GAP
   } arb_state_e;

   localparam int ARB_N_REQ_DEF = 4;
   localparam int ARB_QUOTA_DEF = 8;

endpackage : arb_pkg

// File: rtl/rr_quota_arbiter_if.sv
// ----------------------------------------------------------------------------
// rr_quota_arbiter_if
//   Request/grant bundle between the requesters and the arbiter.
//   Signals:
//      request      N_REQ  level request per requester
//      grant        N_REQ  one-hot or zero grant
//      grant_valid  1      OR of grant
//      grant_id     IDW    index of the granted requester, 0 when none
//      expired      1      pulse when the hold quota forced a release
//   Modports:
//      master       requester side (drives request)
//      slave        arbiter side (drives grant/status)
// ----------------------------------------------------------------------------
interface rr_quota_arbiter_if
   import arb_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ_DEF,
   parameter int IDW   = $clog2(N_REQ)
) ();

   logic [N_REQ-1:0] request;
   logic [N_REQ-1:0] grant;
   logic             grant_valid;
   logic [IDW-1:0]   grant_id;
   logic             expired;

   modport master (
      output request,
      input  grant,
      input  grant_valid,
      input  grant_id,
      input  expired
   );

   modport slave (
      input  request,
      output grant,
      output grant_valid,
      output grant_id,
      output expired
   );

endinterface : rr_quota_arbiter_if

// File: rtl/rr_quota_arbiter_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
//   Combinational round-robin search: finds the first set bit of req starting
//   at position ptr and moving upward, wrapping at N_REQ.
//   Ports:
//      req    in   N_REQ  candidate request vector
//      ptr    in   IDW    starting position of the search
//      found  out  1      at least one bit of req is set
//      idx    out  IDW    index of the winning bit (0 when none found)
// ----------------------------------------------------------------------------
module rr_priority_pick
   import arb_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ_DEF,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic             found,
   output logic [IDW-1:0]   idx
);

   // One extra bit so ptr + offset cannot overflow before the wrap compare.
   logic [IDW:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, ptr} + (IDW+1)'(i);
         // Explicit wrap so non-power-of-2 N_REQ indexes stay in range.
         if (cand >= (IDW+1)'(N_REQ)) begin
            cand = cand - (IDW+1)'(N_REQ);
         end
         if (!found && req[cand[IDW-1:0]]) begin
            found = 1'b1;
            idx   = cand[IDW-1:0];
         end
      end
   end

endmodule : rr_priority_pick

// File: rtl/rr_quota_arbiter.sv
// ----------------------------------------------------------------------------
// rr_quota_arbiter
//   Round-robin arbiter with grant lock and hold-time quota. The owner keeps
//   the grant while its request stays high; once it has held for QUOTA cycles
//   with another requester waiting, it is forced off. Every handoff goes
//   through one dead cycle with no grant, so bus drivers never overlap.
//   Ports:
//      clk     in   1   clock, all state updates on posedge
//      reset   in   1   synchronous, active-high
//      bus     slave modport of rr_quota_arbiter_if
//                       (request in; grant, grant_valid, grant_id, expired out,
//                        all outputs registered)
// ----------------------------------------------------------------------------
module rr_quota_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ_DEF,
   parameter int QUOTA = ARB_QUOTA_DEF,
   parameter int IDW   = $clog2(N_REQ),
   parameter int CW    = $clog2(QUOTA+1)
) (
   input  logic               clk,
   input  logic               reset,
   rr_quota_arbiter_if.slave  bus
);

   arb_state_e       state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic             grant_valid_q;
   logic             expired_q, expired_d;

   logic             pick_found;
   logic [IDW-1:0]   pick_idx;
   logic             owner_req;
   logic             others_req;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   // Pointer moves one past the winner, wrapping by compare (not by masking)
   // so non-power-of-2 N_REQ works.
   function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] i);
      if (i == IDW'(N_REQ-1)) begin
         ptr_after = '0;
      end else begin
         ptr_after = i + 1'b1;
      end
   endfunction

   rr_priority_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_pick (
      .req   (bus.request),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign owner_req  = bus.request[grant_id_q];
   // grant_q is the owner's one-hot, so masking it off leaves the waiters.
   assign others_req = |(bus.request & ~grant_q);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      expired_d  = 1'b0;

      unique case (state_q)
         ARB_IDLE, ARB_GAP: begin
            if (pick_found) begin
               state_d    = ARB_BUSY;
               grant_d    = onehot(pick_idx);
               grant_id_d = pick_idx;
               rr_ptr_d   = ptr_after(pick_idx);
               hold_cnt_d = '0;
            end else begin
               state_d    = ARB_IDLE;
               grant_d    = '0;
               grant_id_d = '0;
            end
         end

         ARB_BUSY: begin
            if (!owner_req) begin
               // Voluntary release takes priority over a quota expiry.
               state_d    = ARB_GAP;
               grant_d    = '0;
               grant_id_d = '0;
               hold_cnt_d = '0;
            end else if (hold_cnt_q == CW'(QUOTA-1)) begin
               if (others_req) begin
                  state_d    = ARB_GAP;
                  grant_d    = '0;
                  grant_id_d = '0;
                  hold_cnt_d = '0;
                  expired_d  = 1'b1;
               end else begin
                  // Nobody waiting: keep the grant and restart the window.
                  hold_cnt_d = '0;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d    = ARB_IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            hold_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ARB_IDLE;
         rr_ptr_q      <= '0;
         hold_cnt_q    <= '0;
         grant_q       <= '0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         expired_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         hold_cnt_q    <= hold_cnt_d;
         grant_q       <= grant_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= |grant_d;
         expired_q     <= expired_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.expired     = expired_q;

endmodule : rr_quota_arbiter

// File: tb/tb_rr_quota_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_quota_arbiter
//   Directed bench for rr_quota_arbiter with N_REQ=4, QUOTA=8. Inputs change
//   1 time unit after the rising edge; outputs are checked at the same point,
//   so every check sees the registers updated by the preceding edge.
// ----------------------------------------------------------------------------
module tb_rr_quota_arbiter;

   logic clk;
   logic reset;
   int   vecs;
   int   errs;

   rr_quota_arbiter_if #(.N_REQ(4), .IDW(2)) bus_if ();

   rr_quota_arbiter #(
      .N_REQ (4),
      .QUOTA (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vecs++;
      assert (obs === exp_v) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                          input logic ex);
      chk({tag, ".grant"},       32'(bus_if.grant),       32'(g));
      chk({tag, ".grant_valid"}, 32'(bus_if.grant_valid), 32'(|g));
      chk({tag, ".grant_id"},    32'(bus_if.grant_id),    32'(id));
      chk({tag, ".expired"},     32'(bus_if.expired),     32'(ex));
   endtask

   initial begin
      logic [1:0] own;
      vecs = 0;
      errs = 0;

      // Reset held for 3 cycles with everyone requesting.
      reset          = 1'b1;
      bus_if.request = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("reset_hold", 4'b0000, 2'd0, 1'b0);
      end
      reset = 1'b0;
      tick();
      chk_out("reset_release", 4'b0001, 2'd0, 1'b0);

      // Quota rotation: all requesting, 8 grant cycles each, gap with expired.
      for (int r = 0; r < 5; r++) begin
         own = 2'(r % 4);
         for (int c = 0; c < 8; c++) begin
            chk_out($sformatf("rot%0d_c%0d", r, c), 4'b0001 << own, own, 1'b0);
            tick();
         end
         chk_out($sformatf("rot%0d_gap", r), 4'b0000, 2'd0, 1'b1);
         tick();
      end
      chk_out("rot_next", 4'b0010, 2'd1, 1'b0);

      // Single requester: grant held continuously, quota never expires.
      reset          = 1'b1;
      bus_if.request = 4'b0100;
      tick();
      chk_out("single_reset", 4'b0000, 2'd0, 1'b0);
      reset = 1'b0;
      tick();
      for (int c = 0; c < 20; c++) begin
         chk_out($sformatf("single_c%0d", c), 4'b0100, 2'd2, 1'b0);
         tick();
      end
      bus_if.request = 4'b0000;
      chk_out("single_last", 4'b0100, 2'd2, 1'b0);
      tick();
      chk_out("single_release", 4'b0000, 2'd0, 1'b0);
      tick();
      chk_out("single_idle", 4'b0000, 2'd0, 1'b0);

      // Voluntary handoff: rr_ptr is 3, owner 3 gets the grant, ptr -> 0.
      bus_if.request = 4'b1000;
      tick();
      chk_out("vol_own3", 4'b1000, 2'd3, 1'b0);
      bus_if.request = 4'b1001;
      tick();
      chk_out("vol_locked", 4'b1000, 2'd3, 1'b0);
      bus_if.request = 4'b0001;
      tick();
      chk_out("vol_gap", 4'b0000, 2'd0, 1'b0);
      tick();
      chk_out("vol_new", 4'b0001, 2'd0, 1'b0);

      // Simultaneous release and quota: owner 0 drops on its 8th cycle.
      bus_if.request = 4'b0011;
      for (int c = 1; c < 8; c++) begin
         tick();
         chk_out($sformatf("sim_c%0d", c), 4'b0001, 2'd0, 1'b0);
      end
      bus_if.request = 4'b0010;
      tick();
      chk_out("sim_gap", 4'b0000, 2'd0, 1'b0);
      bus_if.request = 4'b0110;
      tick();
      chk_out("sim_new", 4'b0010, 2'd1, 1'b0);

      // Reset mid-grant, then rr_ptr restarts at 0.
      reset = 1'b1;
      tick();
      chk_out("midreset", 4'b0000, 2'd0, 1'b0);
      reset = 1'b0;
      tick();
      chk_out("midreset_release", 4'b0010, 2'd1, 1'b0);
      tick();
      chk_out("midreset_hold", 4'b0010, 2'd1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule : tb_rr_quota_arbiter
